usb_bitstuff_nrzi: RTL

- Upstream neighbour of the DP/DM line driver in the USB transmit path.
- Accepts the serial packet bitstream (PID..CRC, LSB-first) from the packet serializer through a valid/ready handshake.
- Inserts a stuff 0 after every MAX_ONES consecutive 1s, NRZI-encodes the result, and drives nrzi_bit/nrzi_sending, one bit per clock, to the line driver.
- Holds off the next packet until the line driver reports out_done (sync flush plus EOP complete).

---
 rtl/usb_bitstuff_nrzi.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/usb_bitstuff_nrzi.sv
// usb_bitstuff_nrzi
//   Bit stuffer and NRZI encoder in the USB transmit path. It sits between the
//   packet serializer and the DP/DM line driver. It takes one raw packet bit
//   per clock (PID..CRC, LSB first) over a valid/ready handshake. After every
//   MAX_ONES consecutive 1s it inserts a stuffed 0, NRZI-encodes the stream
//   and drives it to the line driver one bit per clock. After the packet it
//   holds off new input until the driver signals out_done (EOP complete).
//
// Ports
//   clock, reset_n     system clock, asynchronous active-low reset
//   in_bit_i           raw packet bit
//   in_valid_i         in_bit_i is valid
//   in_last_i          in_bit_i is the final bit of the packet
//   in_ready_o         bit accepted this cycle when in_valid_i is also high
//   out_done_i         one-cycle pulse from the line driver: EOP finished
//   nrzi_bit_o         encoded line bit (1 = J, 0 = K)
//   nrzi_sending_o     nrzi_bit_o is part of the packet
//   err_underrun_o     one-cycle pulse: input starved mid-packet
//   busy_o             high from the first accepted bit until out_done_i

module usb_bitstuff_nrzi #(
    parameter int unsigned MAX_ONES     = 6,
    parameter int unsigned ONES_PRELOAD = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_bit_i,
    input  logic in_valid_i,
    input  logic in_last_i,
    output logic in_ready_o,
    input  logic out_done_i,
    output logic nrzi_bit_o,
    output logic nrzi_sending_o,
    output logic err_underrun_o,
    output logic busy_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        STUFF     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_ONES);
    localparam logic [2:0] PRE_CNT = 3'(ONES_PRELOAD);

    state_t     state_q, state_d;
    logic       level_q, level_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic       last_flag_q, last_flag_d;
    logic       sending_q, sending_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    // Encoding of the bit presented on in_bit_i this cycle
    logic       lvl_base, enc_lvl;
    logic [2:0] cnt_base, enc_cnt;
    state_t     data_next;

    always_comb begin
        in_ready_o = (state_q == IDLE) || (state_q == SEND);

        // Packet start: line was left on K by SYNC, whose trailing 1 already
        // counts toward the first run of ones.
        lvl_base = (state_q == IDLE) ? 1'b0 : level_q;
        cnt_base = (state_q == IDLE) ? PRE_CNT : ones_cnt_q;
        enc_lvl  = in_bit_i ? lvl_base : ~lvl_base;
        enc_cnt  = in_bit_i ? cnt_base + 3'd1 : 3'd0;

        // A pending stuff takes priority over ending the packet, so the
        // stuff bit for the final data bit is always sent.
        if (enc_cnt == MAX_CNT)
            data_next = STUFF;
        else if (in_last_i)
            data_next = WAIT_DONE;
        else
            data_next = SEND;

        state_d     = state_q;
        level_d     = level_q;
        ones_cnt_d  = ones_cnt_q;
        last_flag_d = last_flag_q;
        sending_d   = sending_q;
        err_d       = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                sending_d = 1'b0;
                if (in_valid_i) begin
                    level_d     = enc_lvl;
                    ones_cnt_d  = enc_cnt;
                    last_flag_d = in_last_i;
                    sending_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = data_next;
                end
            end
            SEND: begin
                if (in_valid_i) begin
                    level_d     = enc_lvl;
                    ones_cnt_d  = enc_cnt;
                    last_flag_d = in_last_i;
                    sending_d   = 1'b1;
                    state_d     = data_next;
                end else begin
                    // Starved: truncate; the line driver still appends EOP
                    sending_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = WAIT_DONE;
                end
            end
            STUFF: begin
                level_d    = ~level_q;
                ones_cnt_d = 3'd0;
                sending_d  = 1'b1;
                state_d    = last_flag_q ? WAIT_DONE : SEND;
            end
            WAIT_DONE: begin
                sending_d = 1'b0;
                if (out_done_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            level_q     <= 1'b0;
            ones_cnt_q  <= 3'd0;
            last_flag_q <= 1'b0;
            sending_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            ones_cnt_q  <= ones_cnt_d;
            last_flag_q <= last_flag_d;
            sending_q   <= sending_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    // The line bit is always the current level: level only moves when a bit
    // is emitted, and it is emitted in the same edge.
    assign nrzi_bit_o     = level_q;
    assign nrzi_sending_o = sending_q;
    assign err_underrun_o = err_q;
    assign busy_o         = busy_q;

endmodule
